// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: instruction formats, field bit positions,
// default program base address, and the word-assembly helper.
package mips_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_RAW = 2'd3;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int ADR_HI = 25;
  localparam int ADR_LO = 0;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

  function automatic logic [31:0] assemble(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  func,
    input logic [15:0] imme,
    input logic [25:0] address
  );
    logic [31:0] w;
    w = '0;
    w[OP_HI:OP_LO] = op;
    case (fmt)
      FMT_R: begin
        w[RS_HI:RS_LO] = rs;
        w[RT_HI:RT_LO] = rt;
        w[RD_HI:RD_LO] = rd;
        w[SH_HI:SH_LO] = shamt;
        w[FN_HI:FN_LO] = func;
      end
      FMT_I: begin
        w[RS_HI:RS_LO]   = rs;
        w[RT_HI:RT_LO]   = rt;
        w[IMM_HI:IMM_LO] = imme;
      end
      default: w[ADR_HI:ADR_LO] = address;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ins_fifo2.sv
// Two-entry FIFO holding {instruction, slot index}; occupancy is tracked by an
// explicit EMPTY/ONE/TWO state so the head register is always the output.
module ins_fifo2
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  fifo_state_e  state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FIFO_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= FIFO_EMPTY;
    end else begin
      case (state_q)
        FIFO_EMPTY: begin
          if (push) begin
            head_q  <= din;
            state_q <= FIFO_ONE;
          end
        end
        FIFO_ONE: begin
          // Push with pop replaces the head in place; occupancy stays one.
          if (push && pop) begin
            head_q <= din;
          end else if (push) begin
            tail_q  <= din;
            state_q <= FIFO_TWO;
          end else if (pop) begin
            state_q <= FIFO_EMPTY;
          end
        end
        FIFO_TWO: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= FIFO_ONE;
          end
        end
        default: state_q <= FIFO_EMPTY;
      endcase
    end
  end

  assign dout  = head_q;
  assign full  = (state_q == FIFO_TWO);
  assign empty = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/ins_packer.sv
// Instruction packer: assembles MIPS words from decoded fields and streams
// them out with their target PC, stopping once instruction memory is full.
module ins_packer
  import mips_pkg::*;
#(
  parameter int          IM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                fmt,
  input  logic [5:0]                op,
  input  logic [4:0]                rs,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [4:0]                shamt,
  input  logic [5:0]                func,
  input  logic [15:0]               imme,
  input  logic [25:0]               address,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_ins,
  output logic [31:0]               out_pc,
  output logic                      im_full,
  output logic [$clog2(IM_DEPTH):0] count
);

  localparam int CW = $clog2(IM_DEPTH) + 1;

  logic [CW-1:0]    slot_q, slot_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [31:0]      word;
  logic [CW+31:0]   fifo_din, fifo_dout;
  logic [CW-1:0]    head_slot;
  logic [31:0]      head_off;

  assign word = assemble(fmt, op, rs, rt, rd, shamt, func, imme, address);

  assign im_full   = (slot_q == CW'(IM_DEPTH));
  assign in_ready  = !fifo_full && !im_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign fifo_din  = {word, slot_q};

  ins_fifo2 #(.W(CW + 32)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_ins   = fifo_dout[CW +: 32];
  assign head_slot = fifo_dout[CW-1:0];
  assign head_off  = 32'(head_slot) << 2;
  assign out_pc    = BASE_ADDR + head_off;
  assign count     = count_q;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (flush) begin
      slot_d  = '0;
      count_d = '0;
    end else begin
      if (push) slot_d  = slot_q + CW'(1);
      if (pop)  count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ins_packer.sv
// Self-checking bench for ins_packer: constant vector table, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_ins_packer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  func;
  logic [15:0] imme;
  logic [25:0] address;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        im_full;
  logic [2:0]  count;

  ins_packer #(.IM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .func      (func),
    .imme      (imme),
    .address   (address),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .im_full   (im_full),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of expected {word, pc}, plus push/pop totals.
  logic [63:0] mq[$];
  int pushed = 0;
  int emitted = 0;

  typedef struct {
    logic [1:0]  f;
    logic [5:0]  o;
    logic [4:0]  s, t, d, sh;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [25:0] ad;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word();
    case (fmt)
      2'd0: return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                   (32'(rd) << 11) | (32'(shamt) << 6) | 32'(func);
      2'd1: return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imme);
      default: return (32'(op) << 26) | 32'(address);
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    pushed = 0;
    emitted = 0;
  endtask

  task automatic set_tuple(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                           input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
    fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; func = fn; imme = im; address = ad;
  endtask

  task automatic set_raw(input logic [25:0] ad);
    set_tuple(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, ad);
  endtask

  // Called in the low phase with inputs set: compare, clock once, update model.
  task automatic cycle();
    logic exp_ready, exp_valid, hs_in, hs_out;
    exp_ready = (mq.size() < 2) && (pushed < DEPTH);
    exp_valid = (mq.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("im_full", 32'(im_full), 32'(pushed == DEPTH));
    chk("count", 32'(count), 32'(emitted));
    if (exp_valid) begin
      chk("out_ins", out_ins, mq[0][63:32]);
      chk("out_pc", out_pc, mq[0][31:0]);
    end
    hs_in  = in_valid && exp_ready;
    hs_out = exp_valid && out_ready;
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      if (hs_out) begin
        $display("pop ins=%h pc=%h", mq[0][63:32], mq[0][31:0]);
        void'(mq.pop_front());
        emitted++;
      end
      if (hs_in) begin
        mq.push_back({ref_word(), BASE + 32'(pushed) * 32'd4});
        pushed++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{2'd0, 6'h00, 5'd1,  5'd2, 5'd3,  5'd0,  6'h20, 16'hBEEF, 26'h2AAAAAA, 32'h0022_1820};
    vt[1] = '{2'd1, 6'h0D, 5'd0,  5'd1, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h0000000, 32'h3401_1234};
    vt[2] = '{2'd2, 6'h02, 5'd5,  5'd6, 5'd7,  5'd1,  6'h01, 16'hFFFF, 26'h0000C00, 32'h0800_0C00};
    vt[3] = '{2'd3, 6'h3F, 5'd0,  5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'hFFFF_FFFF};
    vt[4] = '{2'd0, 6'h00, 5'd31, 5'd0, 5'd31, 5'd31, 6'h3F, 16'hAAAA, 26'h1555555, 32'h03E0_FFFF};
    vt[5] = '{2'd1, 6'h23, 5'd29, 5'd8, 5'd17, 5'd9,  6'h15, 16'hFFFC, 26'h2345678, 32'h8FA8_FFFC};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_raw(26'd0);
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ins", out_ins, 32'd0);
    chk("rst_out_pc", out_pc, BASE);
    chk("rst_im_full", 32'(im_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table: each entry is flushed in, pushed alone and popped.
    for (int i = 0; i < 6; i++) begin
      flush = 1'b1; in_valid = 1'b0; cycle();
      flush = 1'b0;
      set_tuple(vt[i].f, vt[i].o, vt[i].s, vt[i].t, vt[i].d, vt[i].sh, vt[i].fn, vt[i].im, vt[i].ad);
      in_valid = 1'b1; out_ready = 1'b0; cycle();
      in_valid = 1'b0;
      chk("tbl_ins", out_ins, vt[i].exp);
      chk("tbl_pc", out_pc, BASE);
      out_ready = 1'b1; cycle();
      out_ready = 1'b0;
      chk("tbl_count", 32'(count), 32'd1);
    end

    // Back-to-back ori then j with out_ready held high.
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    set_tuple(2'd1, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    cycle();
    chk("b2b_ins0", out_ins, 32'h3401_1234);
    chk("b2b_pc0", out_pc, 32'h0000_3000);
    set_tuple(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000C00);
    cycle();
    chk("b2b_ins1", out_ins, 32'h0800_0C00);
    chk("b2b_pc1", out_pc, 32'h0000_3004);
    in_valid = 1'b0; cycle();
    chk("b2b_count", 32'(count), 32'd2);
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third waits until space frees.
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    set_raw(26'd1); cycle();
    set_raw(26'd2); cycle();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    set_raw(26'd3); cycle(); cycle();
    out_ready = 1'b1; cycle();
    chk("bp_pc1", out_pc, 32'h0000_3004);
    cycle();
    chk("bp_pc2", out_pc, 32'h0000_3008);
    chk("bp_ins2", out_ins, 32'd3);
    in_valid = 1'b0; cycle();
    chk("bp_count", 32'(count), 32'd3);

    // Capacity: six offered, only four ever accepted.
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_raw(26'h100 + 26'(k)); cycle();
    end
    in_valid = 1'b0; cycle(); cycle();
    chk("full_im_full", 32'(im_full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);

    // Flush with two buffered and a tuple offered in the flush cycle.
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    set_raw(26'hA1); cycle();
    set_raw(26'hA2); cycle();
    set_raw(26'hA3); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_count", 32'(count), 32'd0);
    set_raw(26'hA5); in_valid = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_empty_push", 32'(out_valid), 32'd0);
    set_raw(26'hA4); in_valid = 1'b1; cycle();
    in_valid = 1'b0;
    chk("fl_next_ins", out_ins, 32'hA4);
    chk("fl_next_pc", out_pc, 32'h0000_3000);
    out_ready = 1'b1; cycle();

    // Asynchronous reset between edges while words are in flight.
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    set_raw(26'hB1); cycle();
    set_raw(26'hB2); cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_ins", out_ins, 32'd0);
    chk("ar_out_pc", out_pc, BASE);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_im_full", 32'(im_full), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    set_raw(26'hB3); in_valid = 1'b1; out_ready = 1'b1; cycle();
    in_valid = 1'b0;
    chk("ar_next_pc", out_pc, 32'h0000_3000);
    chk("ar_next_ins", out_ins, 32'hB3);
    cycle();

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_tuple(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_packer.md
# ins_packer

Instruction packer: the encoding counterpart of the datapath's field splitter. It accepts decoded instruction fields (op, rs, rt, rd, shamt, func, imme, address) over a valid/ready handshake and assembles the 32-bit MIPS word for the selected format. Each word is buffered in a 2-entry FIFO and emitted with valid/ready together with its target PC, so a testbench or boot loader can stream a program into instruction memory. It tracks how many words have been placed and stops accepting input when the instruction memory is full.

## Interface
- IM_DEPTH, 1024, instruction-memory capacity in words (power of two, ≥ 4)
- BASE_ADDR, 32'h0000_3000, PC of the first emitted word
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of FIFO and counters
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- fmt  in  2  0=R, 1=I, 2=J, 3=RAW
- op  in  6  opcode
- rs, rt, rd, shamt  in  5 each  register/shift fields
- func  in  6  function code
- imme  in  16  immediate
- address  in  26  jump index, or low 26 bits in RAW mode
- out_valid  out  1  assembled word available
- out_ready  in  1  consumer accepts
- out_ins  out  32  assembled instruction
- out_pc  out  32  PC of out_ins
- im_full  out  1  IM_DEPTH words emitted or buffered
- count  out  clog2(IM_DEPTH)+1  words emitted so far

## Operation
- Word assembly:
  - R: {op, rs, rt, rd, shamt, func}
  - I: {op, rs, rt, imme}
  - J and RAW: {op, address}
  - Fields not used by the selected format are ignored.
- Push: on in_valid && in_ready, the assembled word is written to the FIFO tail together with its slot index.
- Slot index: a counter that increments on every push.
- Pop: on out_valid && out_ready, the FIFO head is removed and count increments.
- Output: out_ins and out_pc always reflect the FIFO head. out_pc = BASE_ADDR + 4·head_slot, computed in 32 bits and wrapping.
- in_ready = !fifo_full && !im_full. It has no combinational dependence on out_ready or in_valid.
- im_full = (pushed slots == IM_DEPTH). It stays set until flush or reset. The FIFO keeps draining while im_full is set.
- Simultaneous push and pop: both take effect and occupancy is unchanged. This is only possible at occupancy 1, because in_ready is low at occupancy 2.
- out_valid = FIFO non-empty. Once asserted, out_valid holds and out_ins/out_pc stay stable until the pop.
- flush: FIFO emptied, slot counter and count cleared, im_full cleared. A handshake in the same cycle as flush is discarded. flush has priority over push and pop.
- FIFO state machine (occupancy):
  - EMPTY → ONE on push
  - ONE → EMPTY on pop without push
  - ONE → TWO on push without pop
  - ONE stays ONE on push with pop
  - TWO → ONE on pop
  - flush → EMPTY from any state

## Timing
- Reset (async assert, sync release via reset_n):
  - in_ready = 1; out_valid = 0; out_ins = 0; out_pc = BASE_ADDR; im_full = 0; count = 0
  - FIFO EMPTY; slot counter 0
- Latency: a tuple accepted at edge N makes out_valid high after edge N (visible in cycle N+1).
- Throughput: one word per cycle sustained while out_ready is held high.
- Backpressure: with out_ready low, two tuples are accepted, then in_ready drops in the cycle after the second push.
- Reset mid-stream: buffered words are lost and the next accepted word gets PC = BASE_ADDR.

## Structure
- Shared package `mips_pkg` holds:
  - FMT_R / FMT_I / FMT_J / FMT_RAW encodings
  - field bit positions (31:26, 25:21, 20:16, 15:11, 10:6, 5:0, 15:0, 25:0)
  - default BASE_ADDR
- One sub-module, `ins_fifo2`: a 2-entry FIFO with full/empty flags, carrying {ins, slot index}.
- Assembly logic and counters live in the top level.

## Test plan
- R add $3,$1,$2 (op 0, rs 1, rt 2, rd 3, shamt 0, func 0x20) → out_ins 0x00221820, out_pc 0x00003000, count 1 after pop.
- I ori $1,$0,0x1234 (op 0x0D, rt 1) then J j 0x0C00 (op 2), back-to-back with out_ready = 1 → 0x34011234 @ 0x3000, then 0x08000C00 @ 0x3004, one per cycle.
- out_ready held 0, three tuples offered → first two accepted, in_ready 0 from the cycle after the second push. Release out_ready → third tuple accepted; order and PCs 0x3000 / 0x3004 / 0x3008 preserved.
- IM_DEPTH = 4, stream six tuples → exactly four emitted, im_full = 1 and in_ready = 0 afterwards, count = 4.
- flush with two words buffered and in_valid high → out_valid = 0 next cycle, count = 0, next word's PC is 0x3000, flushed-cycle tuple never emitted.
- reset_n pulsed low mid-stream (asynchronously, between edges) → outputs take reset values immediately; after release, the first word emits at PC 0x3000.
